pwm_fade_ctrl: RTL and testbench

- Multi-channel fade sequencer that drives the `compare` inputs of a bank of `pwm` instances (counter width CTR_LEN).
- Each channel moves its compare value one LSB at a time toward a software-written target. The step rate is programmable per channel, in PWM periods per step.
- Compare updates are committed only on the last cycle of a PWM period, so every period sees a stable duty.
- Sits between a register/host interface and the pwm bank.

---
 rtl/pwm_fade_pkg.sv | 17 +
 rtl/pwm_fade_chan.sv | 92 +++++++++
 rtl/pwm_fade_ctrl.sv | 78 +++++++
 tb/tb_pwm_fade_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_fade_pkg.sv
// rtl/pwm_fade_pkg.sv - shared types, defaults and helpers for the pwm fade sequencer
package pwm_fade_pkg;

    typedef enum logic {
        FADE_IDLE = 1'b0,
        FADE_RAMP = 1'b1
    } fade_state_e;

    localparam int DEF_CTR_LEN = 8;
    localparam int DEF_DIV_LEN = 8;

    // Channel index width, never narrower than one bit.
    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/pwm_fade_chan.sv
// rtl/pwm_fade_chan.sv - one fade channel: FSM, target/divider state and compare register
module pwm_fade_chan
    import pwm_fade_pkg::*;
#(
    parameter int CTR_LEN = DEF_CTR_LEN,
    parameter int DIV_LEN = DEF_DIV_LEN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               boundary,
    input  logic               wr_en,
    input  logic [CTR_LEN-1:0] wr_target,
    input  logic [DIV_LEN-1:0] wr_div,
    output logic [CTR_LEN-1:0] compare,
    output logic               busy,
    output logic               done
);

    fade_state_e        state_q, state_d;
    logic [CTR_LEN-1:0] target_q, target_d;
    logic [DIV_LEN-1:0] div_q, div_d;
    logic [DIV_LEN-1:0] cnt_q, cnt_d;
    logic [CTR_LEN-1:0] cmp_q, cmp_d;
    logic               done_q, done_d;
    logic [CTR_LEN-1:0] step;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FADE_IDLE;
            target_q <= '0;
            div_q    <= '0;
            cnt_q    <= '0;
            cmp_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            cmp_q    <= cmp_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        cmp_d    = cmp_q;
        done_d   = 1'b0;
        step     = (target_q > cmp_q) ? cmp_q + CTR_LEN'(1) : cmp_q - CTR_LEN'(1);

        // Writes never coincide with a boundary, so a retarget cannot race a step.
        if (wr_en) begin
            target_d = wr_target;
            div_d    = wr_div;
            cnt_d    = '0;
            if (wr_target != cmp_q) begin
                state_d = FADE_RAMP;
            end else begin
                state_d = FADE_IDLE;
                done_d  = 1'b1;
            end
        end else begin
            case (state_q)
                FADE_RAMP: begin
                    if (boundary) begin
                        if (cnt_q == div_q) begin
                            cnt_d = '0;
                            cmp_d = step;
                            if (step == target_q) begin
                                state_d = FADE_IDLE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + DIV_LEN'(1);
                        end
                    end
                end
                default: begin
                    state_d = FADE_IDLE;
                end
            endcase
        end
    end

    assign compare = cmp_q;
    assign busy    = (state_q == FADE_RAMP);
    assign done    = done_q;

endmodule

// File: rtl/pwm_fade_ctrl.sv
// rtl/pwm_fade_ctrl.sv - multi-channel pwm compare fade sequencer; PWM_FADE_IRQ_EN adds irq outputs
module pwm_fade_ctrl
    import pwm_fade_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CTR_LEN = DEF_CTR_LEN,
    parameter int DIV_LEN = DEF_DIV_LEN
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_valid,
    output logic                            wr_ready,
    input  logic [ch_idx_w(NUM_CH)-1:0]     wr_ch,
    input  logic [CTR_LEN-1:0]              wr_target,
    input  logic [DIV_LEN-1:0]              wr_div,
    output logic [NUM_CH*CTR_LEN-1:0]       compare,
    output logic [NUM_CH-1:0]               busy,
    output logic [NUM_CH-1:0]               done
`ifdef PWM_FADE_IRQ_EN
    ,
    input  logic [NUM_CH-1:0]               irq_mask,
    input  logic [NUM_CH-1:0]               irq_clr,
    output logic                            irq
`endif
);

    localparam int CH_W = ch_idx_w(NUM_CH);

    logic [CTR_LEN-1:0] pctr;
    logic               boundary;
    logic               wr_fire;

    // Tracks the pwm bank's counter; both leave reset together.
    always_ff @(posedge clk) begin
        if (rst) begin
            pctr <= '0;
        end else begin
            pctr <= pctr + CTR_LEN'(1);
        end
    end

    assign boundary = &pctr;
    assign wr_ready = !rst && !boundary;
    assign wr_fire  = wr_valid && wr_ready && (int'(wr_ch) < NUM_CH);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        pwm_fade_chan #(
            .CTR_LEN (CTR_LEN),
            .DIV_LEN (DIV_LEN)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .boundary  (boundary),
            .wr_en     (wr_fire && (wr_ch == CH_W'(i))),
            .wr_target (wr_target),
            .wr_div    (wr_div),
            .compare   (compare[i*CTR_LEN +: CTR_LEN]),
            .busy      (busy[i]),
            .done      (done[i])
        );
    end

`ifdef PWM_FADE_IRQ_EN
    logic [NUM_CH-1:0] irq_stat;

    // A done arriving with its own clear keeps the status bit set.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_stat <= '0;
            irq      <= 1'b0;
        end else begin
            irq_stat <= (irq_stat & ~irq_clr) | done;
            irq      <= |(irq_stat & irq_mask);
        end
    end
`endif

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// tb/tb_pwm_fade_ctrl.sv - directed self-checking bench for pwm_fade_ctrl
module tb_pwm_fade_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [1:0]  wr_ch = '0;
    logic [7:0]  wr_target = '0;
    logic [7:0]  wr_div = '0;
    logic [31:0] compare;
    logic [3:0]  busy;
    logic [3:0]  done;
`ifdef PWM_FADE_IRQ_EN
    logic [3:0]  irq_mask = 4'b1000;
    logic [3:0]  irq_clr = 4'b0000;
    logic        irq;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] m_pctr = '0;

    pwm_fade_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_ch     (wr_ch),
        .wr_target (wr_target),
        .wr_div    (wr_div),
        .compare   (compare),
        .busy      (busy),
        .done      (done)
`ifdef PWM_FADE_IRQ_EN
        ,
        .irq_mask  (irq_mask),
        .irq_clr   (irq_clr),
        .irq       (irq)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) m_pctr <= '0;
        else     m_pctr <= m_pctr + 8'd1;
    end

    function automatic logic [7:0] cmp(input int ch);
        return compare[ch*8 +: 8];
    endfunction

    task automatic wait_pctr(input logic [7:0] v);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_pctr != v && n < 600);
        checks++;
        if (m_pctr != v) begin
            errors++;
            $display("FAIL wait_pctr timeout: pctr %0d required %0d", m_pctr, v);
        end
    endtask

    task automatic wait_done(input int ch, input int limit);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done[ch] !== 1'b1 && n < limit);
        checks++;
        if (done[ch] !== 1'b1) begin
            errors++;
            $display("FAIL wait_done ch%0d timeout: done %b required 1", ch, done[ch]);
        end
    endtask

    task automatic do_write(input logic [1:0] ch, input logic [7:0] tgt, input logic [7:0] dv);
        @(negedge clk);
        if (m_pctr == 8'd255) @(negedge clk);
        wr_valid  = 1'b1;
        wr_ch     = ch;
        wr_target = tgt;
        wr_div    = dv;
        @(negedge clk);
        wr_valid  = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++; $display("FAIL reset_wr_ready: got %b required 0", wr_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (compare !== 32'h0 || busy !== 4'h0 || done !== 4'h0) begin
            errors++;
            $display("FAIL reset_outputs: compare %h busy %b done %b required 0", compare, busy, done);
        end
        checks++;
        if (dut.pctr !== 8'd0) begin
            errors++; $display("FAIL reset_pctr: got %0d required 0", dut.pctr);
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_wr_ready: got %b required 1", wr_ready);
        end
    endtask

    task automatic test_basic_ramp();
        do_write(2'd0, 8'd4, 8'd0);
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++; $display("FAIL ramp_busy_start: got %b required 1", busy[0]);
        end
        wait_pctr(8'd255);
        checks++;
        if (cmp(0) !== 8'd0) begin
            errors++; $display("FAIL ramp_before_boundary: got %0d required 0", cmp(0));
        end
        for (int k = 1; k <= 4; k++) begin
            wait_pctr(8'd0);
            checks++;
            if (cmp(0) !== 8'(k)) begin
                errors++; $display("FAIL ramp_step%0d: got %0d required %0d", k, cmp(0), k);
            end
            checks++;
            if (done[0] !== (k == 4) || busy[0] !== (k != 4)) begin
                errors++;
                $display("FAIL ramp_flags%0d: done %b busy %b required done %b busy %b",
                         k, done[0], busy[0], k == 4, k != 4);
            end
        end
        @(negedge clk);
        checks++;
        if (done[0] !== 1'b0) begin
            errors++; $display("FAIL ramp_done_width: got %b required 0", done[0]);
        end
    endtask

    task automatic test_divider_down();
        do_write(2'd1, 8'd10, 8'd0);
        wait_done(1, 256 * 12);
        checks++;
        if (cmp(1) !== 8'd10) begin
            errors++; $display("FAIL div_preload: got %0d required 10", cmp(1));
        end
        do_write(2'd1, 8'd7, 8'd2);
        for (int n = 1; n <= 9; n++) begin
            wait_pctr(8'd0);
            checks++;
            if (cmp(1) !== 8'(10 - n / 3) || done[1] !== (n == 9)) begin
                errors++;
                $display("FAIL div_period%0d: compare %0d done %b required %0d done %b",
                         n, cmp(1), done[1], 10 - n / 3, n == 9);
            end
        end
    endtask

    task automatic test_boundary_retarget();
        wait_pctr(8'd255);
        wr_valid  = 1'b1;
        wr_ch     = 2'd2;
        wr_target = 8'd200;
        wr_div    = 8'd0;
        #1;
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++; $display("FAIL hs_boundary_ready: got %b required 0", wr_ready);
        end
        @(negedge clk);
        checks++;
        if (busy[2] !== 1'b0 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL hs_not_accepted: busy %b ready %b required busy 0 ready 1", busy[2], wr_ready);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        checks++;
        if (busy[2] !== 1'b1) begin
            errors++; $display("FAIL hs_accepted: busy %b required 1", busy[2]);
        end
        for (int n = 0; n < 70 && cmp(2) != 8'd60; n++) wait_pctr(8'd0);
        checks++;
        if (cmp(2) !== 8'd60) begin
            errors++; $display("FAIL retarget_reach60: got %0d required 60", cmp(2));
        end
        do_write(2'd2, 8'd50, 8'd0);
        for (int n = 1; n <= 10; n++) begin
            wait_pctr(8'd0);
            checks++;
            if (cmp(2) !== 8'(60 - n) || done[2] !== (n == 10)) begin
                errors++;
                $display("FAIL retarget_step%0d: compare %0d done %b required %0d done %b",
                         n, cmp(2), done[2], 60 - n, n == 10);
            end
        end
    endtask

    task automatic test_noop_and_simultaneous();
        do_write(2'd0, 8'd4, 8'd7);
        checks++;
        if (done[0] !== 1'b1 || busy[0] !== 1'b0) begin
            errors++; $display("FAIL noop_done: done %b busy %b required done 1 busy 0", done[0], busy[0]);
        end
        @(negedge clk);
        checks++;
        if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errors++; $display("FAIL noop_after: done %b busy %b required 0 0", done[0], busy[0]);
        end
        wait_pctr(8'd0);
        do_write(2'd0, 8'd6, 8'd0);
        do_write(2'd3, 8'd2, 8'd0);
        wait_pctr(8'd0);
        checks++;
        if (cmp(0) !== 8'd5 || cmp(3) !== 8'd1 || done !== 4'b0000) begin
            errors++;
            $display("FAIL simul_first: ch0 %0d ch3 %0d done %b required 5 1 0000", cmp(0), cmp(3), done);
        end
        wait_pctr(8'd0);
        checks++;
        if (cmp(0) !== 8'd6 || cmp(3) !== 8'd2 || done !== 4'b1001) begin
            errors++;
            $display("FAIL simul_done: ch0 %0d ch3 %0d done %b required 6 2 1001", cmp(0), cmp(3), done);
        end
    endtask

`ifdef PWM_FADE_IRQ_EN
    task automatic test_irq();
        @(negedge clk);
        irq_clr = 4'b1111;
        @(negedge clk);
        irq_clr = 4'b0000;
        repeat (2) @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_cleared: got %b required 0", irq);
        end
        do_write(2'd3, 8'd3, 8'd0);
        wait_done(3, 600);
        repeat (2) @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL irq_rise: got %b required 1", irq);
        end
        do_write(2'd3, 8'd4, 8'd0);
        wait_done(3, 600);
        irq_clr = 4'b1000;
        @(negedge clk);
        irq_clr = 4'b0000;
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL irq_set_wins: got %b required 1", irq);
        end
    endtask
`endif

    task automatic test_reset_mid_ramp();
        do_write(2'd1, 8'd100, 8'd0);
        do_write(2'd2, 8'd0, 8'd0);
        wait_pctr(8'd0);
        wait_pctr(8'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (compare !== 32'h0 || busy !== 4'h0 || done !== 4'h0 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: compare %h busy %b done %b ready %b required all 0",
                     compare, busy, done, wr_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (compare !== 32'h0 || done !== 4'h0 || dut.pctr !== m_pctr) begin
            errors++;
            $display("FAIL rst_after: compare %h done %b pctr %0d required 0 0 %0d",
                     compare, done, dut.pctr, m_pctr);
        end
    endtask

    initial begin
        test_reset();
        test_basic_ramp();
        test_divider_down();
        test_boundary_retarget();
        test_noop_and_simultaneous();
`ifdef PWM_FADE_IRQ_EN
        test_irq();
`endif
        test_reset_mid_ramp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
